// File: rtl/hc05_pkg.sv
// Shared types and constants for the HC-05 transmit scheduler.
// Optional header byte per packet is enabled by HC05_TX_HDR_EN.
package hc05_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    WAIT_END,
    GAP
  } state_t;

  localparam logic [7:0] HDR_BASE = 8'hA0;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_TIMEOUT = 1000000;

endpackage

// File: rtl/hc05_rr_arb.sv
// Combinational round-robin pick: first valid requester after i_ptr.
// Shared with the receive-side dispatcher.
module hc05_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IW = 1
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IW-1:0]    i_ptr,
  output logic             o_any,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx
);

  localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

  logic [IW-1:0] w_j;
  logic          w_hit;

  assign o_any = |i_valid;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_hit = 1'b0;
    w_j = i_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = (w_j == LAST) ? '0 : w_j + 1'b1;
      if (!w_hit && i_valid[w_j]) begin
        w_hit = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx = w_j;
      end
    end
  end

endmodule

// File: rtl/hc05_tx_sched.sv
// Packet round-robin scheduler feeding the single HC-05 UART transmitter.
// Define HC05_TX_HDR_EN to prefix every packet with an 8'hA0|index byte.
module hc05_tx_sched
  import hc05_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         uart_data,
  output logic               uart_flag,
  input  logic               uart_tx_end,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               abort
);

  localparam int IW = (N_REQ > 2) ? 2 : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t            r_state, w_state;
  logic [N_REQ-1:0]  r_grant, w_grant;
  logic [IW-1:0]     r_ptr, w_ptr;
  logic [7:0]        r_data, w_data;
  logic              r_flag, w_flag;
  logic              r_last, w_last;
  logic              r_abort, w_abort;
  logic              r_busy;
  logic [31:0]       r_tcnt, w_tcnt;
  logic [31:0]       r_gcnt, w_gcnt;

  logic              w_any;
  logic [N_REQ-1:0]  w_arb_gnt;
  logic [IW-1:0]     w_arb_idx;
  logic              w_sel_valid;
  logic [7:0]        w_sel_data;
  logic              w_sel_last;
  logic              w_end;

  hc05_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_any   (w_any),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx)
  );

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_sel_data = req_data[8*i +: 8];
        w_sel_last = req_last[i];
      end
    end
  end

  assign w_sel_valid = |(req_valid & r_grant);
  // an end pulse coincident with our own strobe belongs to the previous byte
  assign w_end = uart_tx_end & ~r_flag;

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_ptr = r_ptr;
    w_data = r_data;
    w_flag = 1'b0;
    w_last = r_last;
    w_abort = 1'b0;
    w_tcnt = r_tcnt;
    w_gcnt = r_gcnt;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant = w_arb_gnt;
          w_ptr = w_arb_idx;
          w_tcnt = '0;
`ifdef HC05_TX_HDR_EN
          w_state = HDR;
          w_data = HDR_BASE | 8'(w_arb_idx);
          w_flag = 1'b1;
`else
          w_state = FETCH;
`endif
        end
      end
      HDR: begin
        if (w_end) begin
          w_state = FETCH;
          w_tcnt = '0;
        end
      end
      FETCH: begin
        if (w_sel_valid) begin
          w_data = w_sel_data;
          w_last = w_sel_last;
          w_flag = 1'b1;
          w_tcnt = '0;
          w_state = WAIT_END;
        end else if (r_tcnt == TO_LAST) begin
          w_abort = 1'b1;
          w_grant = '0;
          w_gcnt = '0;
          w_state = POST;
        end else begin
          w_tcnt = r_tcnt + 32'd1;
        end
      end
      WAIT_END: begin
        if (w_end) begin
          if (r_last) begin
            w_gcnt = '0;
            w_state = POST;
          end else begin
            w_tcnt = '0;
            w_state = FETCH;
          end
        end
      end
      GAP: begin
        if (r_gcnt == GAP_LAST) begin
          w_gcnt = '0;
          w_state = IDLE;
        end else begin
          w_gcnt = r_gcnt + 32'd1;
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_state == IDLE) w_grant = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr <= PTR_RST;
      r_data <= '0;
      r_flag <= 1'b0;
      r_last <= 1'b0;
      r_abort <= 1'b0;
      r_busy <= 1'b0;
      r_tcnt <= '0;
      r_gcnt <= '0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_ptr <= w_ptr;
      r_data <= w_data;
      r_flag <= w_flag;
      r_last <= w_last;
      r_abort <= w_abort;
      r_busy <= (w_state != IDLE);
      r_tcnt <= w_tcnt;
      r_gcnt <= w_gcnt;
    end
  end

  assign req_ready = (r_state == FETCH) ? r_grant : '0;
  assign uart_data = r_data;
  assign uart_flag = r_flag;
  assign grant = r_grant;
  assign busy = r_busy;
  assign abort = r_abort;

endmodule

// File: tb/tb_hc05_tx_sched.sv
// Directed bench for hc05_tx_sched: two requesters, gap 16, timeout 100.
// Expected strobe streams include header bytes when HC05_TX_HDR_EN is set.
module tb_hc05_tx_sched;

`ifdef HC05_TX_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [7:0]  uart_data;
  logic        uart_flag;
  logic        uart_tx_end;
  logic [1:0]  grant;
  logic        busy;
  logic        abort;

  logic tx_end_auto = 1'b0;
  logic tx_end_man = 1'b0;
  logic tx_auto = 1'b1;
  assign uart_tx_end = tx_end_auto | tx_end_man;

  hc05_tx_sched #(
    .N_REQ      (2),
    .GAP_CYCLES (16),
    .TIMEOUT    (100)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .uart_data   (uart_data),
    .uart_flag   (uart_flag),
    .uart_tx_end (uart_tx_end),
    .grant       (grant),
    .busy        (busy),
    .abort       (abort)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // requester byte sources: main appends, driver consumes on handshake
  logic [8:0] m0 [64];
  logic [8:0] m1 [64];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  logic hs0, hs1;

  always begin
    @(negedge sys_clk);
    hs0 = req_valid[0] & req_ready[0];
    hs1 = req_valid[1] & req_ready[1];
    @(posedge sys_clk);
    #1;
    if (hs0) rd0++;
    if (hs1) rd1++;
    req_valid = {rd1 != wr1, rd0 != wr0};
    req_data = {m1[rd1][7:0], m0[rd0][7:0]};
    req_last = {m1[rd1][8], m0[rd0][8]};
  end

  task automatic push0(input logic [7:0] d, input logic l);
    m0[wr0] = {l, d};
    wr0++;
  endtask

  task automatic push1(input logic [7:0] d, input logic l);
    m1[wr1] = {l, d};
    wr1++;
  endtask

  // transmitter model: end-of-byte pulse 20 cycles after each strobe
  time last_end_t = 0;
  always begin
    @(negedge sys_clk);
    if (uart_flag && tx_auto) begin
      repeat (20) @(negedge sys_clk);
      tx_end_auto = 1'b1;
      last_end_t = $time;
      @(negedge sys_clk);
      tx_end_auto = 1'b0;
    end
  end

  logic [9:0] slog [$];
  int abort_cnt = 0;
  time abort_t = 0;
  logic [1:0] abort_g = '0;
  int tnum = 0;
  int gbad = 0;

  always @(negedge sys_clk) begin
    if (uart_flag) slog.push_back({grant, uart_data});
    if (abort) begin
      abort_cnt++;
      abort_t = $time;
      abort_g = grant;
    end
    if (tnum == 1 && busy && grant != 2'b01) gbad++;
  end

  logic [9:0] exq [$];
  int base = 0;

  task automatic exp_hdr(input logic [1:0] g);
    if (HDR_ON) exq.push_back({g, 8'hA0 | {7'd0, g[1]}});
  endtask

  task automatic exp_b(input logic [1:0] g, input logic [7:0] d);
    exq.push_back({g, d});
  endtask

  task automatic start_test(input int t);
    tnum = t;
    base = slog.size();
    exq.delete();
  endtask

  task automatic check_log(input string tag);
    int n;
    n = slog.size() - base;
    chk($sformatf("%s_count", tag), n, exq.size());
    for (int i = 0; i < exq.size() && i < n; i++)
      chk($sformatf("%s_strobe%0d", tag, i), slog[base + i], exq[i]);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge sys_clk);
      n++;
    end
    chk($sformatf("%s_idle", tag), busy, 0);
  endtask

  task automatic wait_grant(input string tag, input int max,
                            output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (grant == 0 && n < max);
    if (grant == 0) chk($sformatf("%s_grant_to", tag), 0, 1);
  endtask

  task automatic wait_flag(input int max, output int n);
    n = 0;
    while (!uart_flag && n < max) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic wait_strobes(input string tag, input int cnt,
                              input int max);
    int n = 0;
    while ((slog.size() - base) < cnt && n < max) begin
      @(negedge sys_clk);
      n++;
    end
    if ((slog.size() - base) < cnt)
      chk($sformatf("%s_strobe_to", tag), slog.size() - base, cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nf, ab0;

    // reset values
    repeat (2) @(negedge sys_clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flag", uart_flag, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_abort", abort, 0);
    chk("rst_ready", req_ready, 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // three-byte packet from requester 0
    start_test(1);
    exp_hdr(2'b01);
    exp_b(2'b01, 8'h11);
    exp_b(2'b01, 8'h22);
    exp_b(2'b01, 8'h33);
    push0(8'h11, 1'b0);
    push0(8'h22, 1'b0);
    push0(8'h33, 1'b1);
    wait_grant("t1", 10, n);
    chk("t1_grant_lat", n, 2);
    chk("t1_grant", grant, 2'b01);
    chk("t1_ready", req_ready, HDR_ON ? 2'b00 : 2'b01);
    wait_flag(10, nf);
    chk("t1_flag_lat", nf, HDR_ON ? 0 : 1);
    chk("t1_first_data", uart_data, HDR_ON ? 8'hA0 : 8'h11);
    wait_idle("t1", 400);
    chk("t1_gap_len", 32'(($time - last_end_t) / 10), 17);
    chk("t1_grant_idle", grant, 0);
    chk("t1_grant_held", gbad, 0);
    check_log("t1");

    // round robin with both requesters valid from reset
    do_reset();
    start_test(2);
    exp_hdr(2'b01);
    exp_b(2'b01, 8'h01);
    exp_b(2'b01, 8'h02);
    exp_hdr(2'b10);
    exp_b(2'b10, 8'h81);
    exp_b(2'b10, 8'h82);
    exp_hdr(2'b01);
    exp_b(2'b01, 8'h03);
    exp_b(2'b01, 8'h04);
    exp_hdr(2'b10);
    exp_b(2'b10, 8'h83);
    exp_b(2'b10, 8'h84);
    push0(8'h01, 1'b0);
    push0(8'h02, 1'b1);
    push0(8'h03, 1'b0);
    push0(8'h04, 1'b1);
    push1(8'h81, 1'b0);
    push1(8'h82, 1'b1);
    push1(8'h83, 1'b0);
    push1(8'h84, 1'b1);
    wait_strobes("t2", exq.size(), 2000);
    wait_idle("t2", 400);
    check_log("t2");

    // requester 1 stalls mid-packet and times out
    do_reset();
    start_test(3);
    ab0 = abort_cnt;
    exp_hdr(2'b10);
    exp_b(2'b10, 8'hAB);
    exp_hdr(2'b01);
    exp_b(2'b01, 8'h5A);
    push1(8'hAB, 1'b0);
    wait_grant("t3", 10, n);
    chk("t3_grant", grant, 2'b10);
    push0(8'h5A, 1'b1);
    n = 0;
    while (abort_cnt == ab0 && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t3_abort_seen", abort_cnt - ab0, 1);
    chk("t3_abort_time", 32'((abort_t - last_end_t) / 10), 101);
    chk("t3_abort_grant", abort_g, 0);
    wait_strobes("t3", exq.size(), 600);
    wait_idle("t3", 400);
    chk("t3_abort_once", abort_cnt - ab0, 1);
    check_log("t3");

    // end pulses in IDLE and in the strobe cycle are ignored
    do_reset();
    start_test(4);
    exp_hdr(2'b01);
    exp_b(2'b01, 8'h5C);
    tx_auto = 1'b0;
    tx_end_man = 1'b1;
    @(negedge sys_clk);
    tx_end_man = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_strobes", slog.size() - base, 0);
    push0(8'h5C, 1'b1);
    wait_grant("t4", 10, n);
    wait_flag(10, nf);
    chk("t4_flag", uart_flag, 1);
    tx_end_man = 1'b1;
    @(negedge sys_clk);
    tx_end_man = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("t4_still_busy", busy, 1);
    chk("t4_still_grant", grant, 2'b01);
    chk("t4_no_early", slog.size() - base, 1);
    tx_auto = 1'b1;
    tx_end_man = 1'b1;
    @(negedge sys_clk);
    tx_end_man = 1'b0;
    wait_strobes("t4", exq.size(), 200);
    wait_idle("t4", 400);
    check_log("t4");

    // reset while a byte is in flight
    do_reset();
    start_test(5);
    tx_auto = 1'b0;
    push0(8'h55, 1'b1);
    wait_grant("t5", 10, n);
    wait_flag(10, nf);
    chk("t5_data", uart_data, HDR_ON ? 8'hA0 : 8'h55);
    repeat (3) @(negedge sys_clk);
    chk("t5_busy_pre", busy, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_flag", uart_flag, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    base = slog.size();
    repeat (30) @(negedge sys_clk);
    chk("t5_no_strobe", slog.size() - base, 0);
    chk("t5_busy_post", busy, 0);
    tx_auto = 1'b1;

    // one-byte packet from requester 1
    do_reset();
    start_test(6);
    exp_hdr(2'b10);
    exp_b(2'b10, 8'h7E);
    push1(8'h7E, 1'b1);
    wait_strobes("t6", exq.size(), 200);
    wait_idle("t6", 400);
    check_log("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
